// File: rtl/apb_pkg.sv
// Shared definitions for the APB register slave: register offsets,
// CTRL field positions and the bus-side FSM state type.
package apb_pkg;

    localparam logic [31:0] CTRL_OFS     = 32'h00;
    localparam logic [31:0] SCRATCH0_OFS = 32'h04;
    localparam logic [31:0] SCRATCH1_OFS = 32'h08;
    localparam logic [31:0] EVT_OFS      = 32'h0C;
    localparam logic [31:0] ID_OFS       = 32'h10;
    localparam logic [31:0] XFER_CNT_OFS = 32'h14;
    localparam logic [31:0] WINDOW_LAST  = 32'h17;

    localparam int WAIT_LSB = 0;
    localparam int WAIT_W   = 4;
    localparam int MASK_LSB = 8;
    localparam int MASK_W   = 8;
    localparam int EVT_W    = 8;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } apb_slv_state_t;

endpackage

// File: rtl/apb_slave_regs.sv
// Register bank behind the APB slave: address/error decode, CTRL, scratch
// registers, sticky W1C event flags, interrupt and completed-transfer counter.
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_A000,
    parameter logic [31:0] ID_VALUE  = 32'h0571_0016
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic [31:0]       paddr,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    input  logic              complete,
    input  logic [EVT_W-1:0]  evt_i,
    output logic [31:0]       rdata,
    output logic              dec_err,
    output logic [WAIT_W-1:0] wait_val,
    output logic              irq_o
);

    logic [31:0]       ofs;
    logic              in_range;
    logic              misaligned;
    logic              ro_write;
    logic              commit;
    logic              wr_en;
    logic [EVT_W-1:0]  evt_clr;

    logic [WAIT_W-1:0] wait_q;
    logic [MASK_W-1:0] mask_q;
    logic [31:0]       scratch0_q;
    logic [31:0]       scratch1_q;
    logic [EVT_W-1:0]  evt_q;
    logic [31:0]       xfer_cnt_q;

    // Offset is only meaningful when paddr >= BASE_ADDR, so it never wraps when in range.
    assign ofs        = paddr - BASE_ADDR;
    assign in_range   = (paddr >= BASE_ADDR) && (ofs <= WINDOW_LAST);
    assign misaligned = (paddr[1:0] != 2'b00);
    assign ro_write   = pwrite && ((ofs == ID_OFS) || (ofs == XFER_CNT_OFS));
    assign dec_err    = !in_range || misaligned || ro_write;

    assign commit   = complete && !dec_err;
    assign wr_en    = commit && pwrite;
    assign evt_clr  = (wr_en && (ofs == EVT_OFS)) ? pwdata[EVT_W-1:0] : '0;
    assign wait_val = wait_q;
    assign irq_o    = |(evt_q & mask_q);

    always_comb begin
        rdata = '0;
        case (ofs)
            CTRL_OFS: begin
                rdata[WAIT_LSB +: WAIT_W] = wait_q;
                rdata[MASK_LSB +: MASK_W] = mask_q;
            end
            SCRATCH0_OFS: rdata = scratch0_q;
            SCRATCH1_OFS: rdata = scratch1_q;
            EVT_OFS:      rdata[EVT_W-1:0] = evt_q;
            ID_OFS:       rdata = ID_VALUE;
            XFER_CNT_OFS: rdata = xfer_cnt_q;
            default:      rdata = '0;
        endcase
    end

    // Event set wins over a simultaneous W1C clear of the same bit.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wait_q     <= '0;
            mask_q     <= '0;
            scratch0_q <= '0;
            scratch1_q <= '0;
            evt_q      <= '0;
            xfer_cnt_q <= '0;
        end else begin
            evt_q <= (evt_q & ~evt_clr) | evt_i;
            if (commit) begin
                xfer_cnt_q <= xfer_cnt_q + 32'd1;
            end
            if (wr_en) begin
                case (ofs)
                    CTRL_OFS: begin
                        wait_q <= pwdata[WAIT_LSB +: WAIT_W];
                        mask_q <= pwdata[MASK_LSB +: MASK_W];
                    end
                    SCRATCH0_OFS: scratch0_q <= pwdata;
                    SCRATCH1_OFS: scratch1_q <= pwdata;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// APB3 completer with programmable wait states; the FSM and wait counter live
// here, the register bank and decode live in apb_slave_regs.
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_A000,
    parameter logic [31:0] ID_VALUE  = 32'h0571_0016
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             psel,
    input  logic             penable,
    input  logic [31:0]      paddr,
    input  logic             pwrite,
    input  logic [31:0]      pwdata,
    output logic [31:0]      prdata,
    output logic             pready,
    output logic             pslverr,
    input  logic [EVT_W-1:0] evt_i,
    output logic             irq_o
);

    apb_slv_state_t    state;
    logic [WAIT_W-1:0] cnt;
    logic [WAIT_W-1:0] wait_val;
    logic [31:0]       rdata;
    logic              dec_err;
    logic              complete;
    logic              proto_err;

    assign complete  = (state == ST_ACCESS) && psel && penable && (cnt == '0);
    assign proto_err = (state == ST_IDLE) && psel && penable;
    assign pready    = complete || proto_err;
    assign pslverr   = proto_err || (complete && dec_err);
    assign prdata    = (complete && !dec_err && !pwrite) ? rdata : '0;

    // Wait count is sampled at setup, so a CTRL write only affects later transfers.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (psel && !penable) begin
                        state <= ST_ACCESS;
                        cnt   <= wait_val;
                    end
                end
                ST_ACCESS: begin
                    if (!psel) begin
                        state <= ST_IDLE;
                    end else if (penable) begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    apb_slave_regs #(
        .BASE_ADDR (BASE_ADDR),
        .ID_VALUE  (ID_VALUE)
    ) u_regs (
        .pclk     (pclk),
        .preset_n (preset_n),
        .paddr    (paddr),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .complete (complete),
        .evt_i    (evt_i),
        .rdata    (rdata),
        .dec_err  (dec_err),
        .wait_val (wait_val),
        .irq_o    (irq_o)
    );

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed self-checking bench for apb_reg_slave: register access, wait states,
// error responses, W1C events/interrupt, abort and mid-transfer reset.
module tb_apb_reg_slave;

    logic        pclk;
    logic        preset_n;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [7:0]  evt_i;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        er;
    int          cyc;

    apb_reg_slave dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .psel     (psel),
        .penable  (penable),
        .paddr    (paddr),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .evt_i    (evt_i),
        .irq_o    (irq_o)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One full APB transfer; inputs change on the falling edge, outputs are sampled 1 unit later.
    task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err, output int cycles);
        logic done;
        done  = 1'b0;
        rdata = '0;
        err   = 1'b0;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata;
        cycles = 1;
        @(negedge pclk);
        penable = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            cycles++;
            if (pready) begin
                done  = 1'b1;
                rdata = prdata;
                err   = pslverr;
            end else begin
                @(negedge pclk);
            end
        end
        if (!done) checkOutput("pready_timeout", 32'd0, 32'd1);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic resetDut();
        @(negedge pclk);
        preset_n = 1'b0;
        repeat (2) @(negedge pclk);
        preset_n = 1'b1;
    endtask

    initial begin
        preset_n = 1'b0;
        psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0; evt_i = '0;
        repeat (2) @(negedge pclk);
        #1;
        checkOutput("rst_prdata", prdata, 32'h0);
        checkOutput("rst_pready", {31'd0, pready}, 32'd0);
        checkOutput("rst_pslverr", {31'd0, pslverr}, 32'd0);
        checkOutput("rst_irq", {31'd0, irq_o}, 32'd0);
        @(negedge pclk);
        preset_n = 1'b1;

        applyStimulus(32'h0000_A010, 1'b0, 32'h0, rd, er, cyc);
        checkOutput("id_data", rd, 32'h0571_0016);
        checkOutput("id_err", {31'd0, er}, 32'd0);
        checkOutput("id_cycles", cyc, 32'd2);

        // Fresh counter for the XFER_CNT expectations below.
        resetDut();
        applyStimulus(32'h0000_A004, 1'b1, 32'hDEAD_BEEF, rd, er, cyc);
        checkOutput("s0_wr_err", {31'd0, er}, 32'd0);
        applyStimulus(32'h0000_A004, 1'b0, 32'h0, rd, er, cyc);
        checkOutput("s0_rd", rd, 32'hDEAD_BEEF);
        applyStimulus(32'h0000_A014, 1'b0, 32'h0, rd, er, cyc);
        checkOutput("cnt_2", rd, 32'd2);

        applyStimulus(32'h0000_A000, 1'b1, 32'h0000_0003, rd, er, cyc);
        checkOutput("ctrl_wr_old_wait", cyc, 32'd2);
        applyStimulus(32'h0000_A008, 1'b0, 32'h0, rd, er, cyc);
        checkOutput("s1_rd", rd, 32'h0);
        checkOutput("wait3_cycles", cyc, 32'd5);

        applyStimulus(32'h0000_A020, 1'b0, 32'h0, rd, er, cyc);
        checkOutput("oor_err", {31'd0, er}, 32'd1);
        checkOutput("oor_data", rd, 32'h0);
        applyStimulus(32'h0000_A006, 1'b0, 32'h0, rd, er, cyc);
        checkOutput("misalign_err", {31'd0, er}, 32'd1);
        checkOutput("misalign_data", rd, 32'h0);
        applyStimulus(32'h0000_A010, 1'b1, 32'h1234_5678, rd, er, cyc);
        checkOutput("ro_wr_err", {31'd0, er}, 32'd1);
        applyStimulus(32'h0000_A014, 1'b0, 32'h0, rd, er, cyc);
        checkOutput("cnt_after_err", rd, 32'd5);
        applyStimulus(32'h0000_A010, 1'b0, 32'h0, rd, er, cyc);
        checkOutput("id_intact", rd, 32'h0571_0016);

        applyStimulus(32'h0000_A000, 1'b1, 32'h0000_0400, rd, er, cyc);
        checkOutput("ctrl_mask_cycles", cyc, 32'd5);
        #1;
        checkOutput("irq_no_evt", {31'd0, irq_o}, 32'd0);
        @(negedge pclk);
        evt_i = 8'h05;
        @(negedge pclk);
        evt_i = 8'h00;
        #1;
        checkOutput("irq_set", {31'd0, irq_o}, 32'd1);
        applyStimulus(32'h0000_A00C, 1'b0, 32'h0, rd, er, cyc);
        checkOutput("evt_05", rd, 32'h05);
        evt_i = 8'h04;
        applyStimulus(32'h0000_A00C, 1'b1, 32'h04, rd, er, cyc);
        evt_i = 8'h00;
        applyStimulus(32'h0000_A00C, 1'b0, 32'h0, rd, er, cyc);
        checkOutput("evt_set_wins", rd, 32'h05);
        applyStimulus(32'h0000_A00C, 1'b1, 32'h04, rd, er, cyc);
        #1;
        checkOutput("irq_cleared", {31'd0, irq_o}, 32'd0);
        applyStimulus(32'h0000_A00C, 1'b0, 32'h0, rd, er, cyc);
        checkOutput("evt_01", rd, 32'h01);

        applyStimulus(32'h0000_A000, 1'b1, 32'h0000_0002, rd, er, cyc);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; paddr = 32'h0000_A004; pwrite = 1'b1; pwdata = 32'h1234_5678;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        checkOutput("abort_wait", {31'd0, pready}, 32'd0);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        applyStimulus(32'h0000_A004, 1'b0, 32'h0, rd, er, cyc);
        checkOutput("abort_s0", rd, 32'hDEAD_BEEF);
        checkOutput("wait2_cycles", cyc, 32'd4);
        applyStimulus(32'h0000_A014, 1'b0, 32'h0, rd, er, cyc);
        checkOutput("abort_cnt", rd, 32'd15);

        @(negedge pclk);
        psel = 1'b1; penable = 1'b1; paddr = 32'h0000_A004; pwrite = 1'b0;
        #1;
        checkOutput("proto_pready", {31'd0, pready}, 32'd1);
        checkOutput("proto_slverr", {31'd0, pslverr}, 32'd1);
        checkOutput("proto_data", prdata, 32'h0);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;

        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; paddr = 32'h0000_A008; pwrite = 1'b1; pwdata = 32'hCAFE_F00D;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        preset_n = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        #1;
        checkOutput("midrst_pready", {31'd0, pready}, 32'd0);
        @(negedge pclk);
        preset_n = 1'b1;
        applyStimulus(32'h0000_A014, 1'b0, 32'h0, rd, er, cyc);
        checkOutput("midrst_cnt", rd, 32'd0);
        checkOutput("midrst_cycles", cyc, 32'd2);
        applyStimulus(32'h0000_A000, 1'b0, 32'h0, rd, er, cyc);
        checkOutput("midrst_ctrl", rd, 32'h0);
        applyStimulus(32'h0000_A004, 1'b0, 32'h0, rd, er, cyc);
        checkOutput("midrst_s0", rd, 32'h0);
        applyStimulus(32'h0000_A008, 1'b0, 32'h0, rd, er, cyc);
        checkOutput("midrst_s1", rd, 32'h0);
        applyStimulus(32'h0000_A00C, 1'b0, 32'h0, rd, er, cyc);
        checkOutput("midrst_evt", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
